// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-RAM arbiter.
// The arbitration mode is selected by the DMEM_ARB_RR_EN macro (see dmem_arb_pick).
package dmem_arb_pkg;

    // Sequencer states: grant happens in IDLE, the RESP states return the result.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESP_CPU = 2'd1,
        RESP_DBG = 2'd2
    } state_e;

    // Identity of the requester that owns (or last owned) the RAM.
    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } grant_e;

    // The debug/loader port always writes whole words.
    localparam logic [3:0] DBG_WMASK = 4'hF;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU data port, debug/loader port and RAM-side bus of the
// data-memory arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the requesters and the RAM model around it.
interface dmem_arbiter_if #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 256
);
    localparam int AW = $clog2(MEM_WORDS);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_wmask;
    logic              cpu_ready;
    logic [31:0]       cpu_rdata;
    logic              cpu_err;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_ready;
    logic [31:0]       dbg_rdata;
    logic              dbg_err;

    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
        output cpu_ready, cpu_rdata, cpu_err,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ready, dbg_rdata, dbg_err,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
        input  cpu_ready, cpu_rdata, cpu_err,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ready, dbg_rdata, dbg_err,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: stateless winner selection between the CPU and debug ports.
// DMEM_ARB_RR_EN defined: round-robin on ties (port opposite last_grant wins).
// DMEM_ARB_RR_EN undefined: fixed priority, debug over CPU.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic   cpu_req_i,
    input  logic   dbg_req_i,
    input  grant_e last_grant_i,
    output logic   gnt_vld_o,
    output grant_e gnt_o
);

`ifndef DMEM_ARB_RR_EN
    // Fixed priority keeps last_grant only for observability.
    logic unused_last_grant;
    assign unused_last_grant = (last_grant_i == GNT_DBG);
`endif

    // Choose the winner from the current requests.
    always_comb begin
        gnt_vld_o = cpu_req_i | dbg_req_i;
        gnt_o     = GNT_CPU;
`ifdef DMEM_ARB_RR_EN
        if (cpu_req_i && dbg_req_i) begin
            gnt_o = (last_grant_i == GNT_DBG) ? GNT_CPU : GNT_DBG;
        end else if (dbg_req_i) begin
            gnt_o = GNT_DBG;
        end
`else
        if (dbg_req_i) begin
            gnt_o = GNT_DBG;
        end
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU data port and
// the debug/loader port. One access per two cycles: grant and RAM strobe in
// IDLE, one-cycle ready pulse in the following RESP state. Errored accesses
// (misaligned or beyond MEM_WORDS) skip the RAM but still get a ready with err.
// Arbitration mode: macro DMEM_ARB_RR_EN (round-robin) else fixed debug priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    bus,
    output logic             cpu_stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] WORD_LIM = ADDR_W'(MEM_WORDS);

    state_e            state_q, state_d;
    grant_e            last_grant_q;
    grant_e            gnt;
    logic              gnt_vld;
    logic              grant;
    logic              rsp_err_q;
    logic              rsp_load_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              cpu_ready;
    logic              dbg_ready;

    logic              sel_we;
    logic              sel_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_wmask;

    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= WORD_LIM);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    dmem_arb_pick u_pick (
        .cpu_req_i    (bus.cpu_req),
        .dbg_req_i    (bus.dbg_req),
        .last_grant_i (last_grant_q),
        .gnt_vld_o    (gnt_vld),
        .gnt_o        (gnt)
    );

    // A grant only happens in IDLE and never while reset is held.
    assign grant = reset && (state_q == IDLE) && gnt_vld;

    // Route the winner's request fields and classify the access.
    always_comb begin
        if (gnt == GNT_DBG) begin
            sel_we    = bus.dbg_we;
            sel_addr  = bus.dbg_addr;
            sel_wdata = bus.dbg_wdata;
            sel_wmask = DBG_WMASK;
        end else begin
            sel_we    = bus.cpu_we;
            sel_addr  = bus.cpu_addr;
            sel_wdata = bus.cpu_wdata;
            sel_wmask = bus.cpu_wmask;
        end
        sel_err = addr_err(sel_addr);
    end

    // Drive the RAM strobes in the grant cycle only; write fields only for stores.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 32'h0;
        bus.mem_wmask = 4'h0;
        if (grant && !sel_err) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = sel_we;
            bus.mem_addr = sel_addr[AW+1:2];
            if (sel_we) begin
                bus.mem_wdata = sel_wdata;
                bus.mem_wmask = sel_wmask;
            end
        end
    end

    // Next state: grant moves to the winner's RESP state, RESP always returns to IDLE.
    always_comb begin
        state_d = IDLE;
        if (grant) begin
            state_d = (gnt == GNT_DBG) ? RESP_DBG : RESP_CPU;
        end
    end

    // Sequencer, response qualifiers and stall counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_DBG;
            rsp_err_q    <= 1'b0;
            rsp_load_q   <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                last_grant_q <= gnt;
                rsp_err_q    <= sel_err;
                rsp_load_q   <= !sel_we;
            end
            if (cpu_stall_o) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign cpu_ready = reset && (state_q == RESP_CPU);
    assign dbg_ready = reset && (state_q == RESP_DBG);

    assign bus.cpu_ready = cpu_ready;
    assign bus.cpu_err   = cpu_ready && rsp_err_q;
    assign bus.cpu_rdata = (cpu_ready && rsp_load_q && !rsp_err_q) ? bus.mem_rdata : 32'h0;

    assign bus.dbg_ready = dbg_ready;
    assign bus.dbg_err   = dbg_ready && rsp_err_q;
    assign bus.dbg_rdata = (dbg_ready && rsp_load_q && !rsp_err_q) ? bus.mem_rdata : 32'h0;

    assign cpu_stall_o = bus.cpu_req && !cpu_ready;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencing controller and two-port arbiter for the single-port data RAM of the RV32I core. It shares the RAM between the CPU data port (load/store) and a debug/loader port, which preloads and inspects memory. It serializes accesses through a small FSM and returns a per-port ready pulse. It also raises a stall to the single-cycle CPU while its access is pending.

## Interface
- MEM_WORDS, 256, RAM depth in 32-bit words; byte addresses `[ADDR_W-1:2]` index words.
- ADDR_W, 32, byte-address width of both requester ports.
- CNT_W, 16, width of the stall counter.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low.
- cpu_req / dbg_req  in  1  access request; held with its fields until the matching ready.
- cpu_we / dbg_we  in  1  1 = store, 0 = load.
- cpu_addr / dbg_addr  in  ADDR_W  byte address.
- cpu_wdata / dbg_wdata  in  32  store data.
- cpu_wmask  in  4  byte enables for CPU stores; the debug port always writes 4'hF.
- cpu_ready / dbg_ready  out  1  one-cycle completion pulse.
- cpu_rdata / dbg_rdata  out  32  load data, valid only while the matching ready is high, else 0.
- cpu_err / dbg_err  out  1  valid with ready: misaligned or out-of-range access.
- cpu_stall  out  1  `cpu_req & ~cpu_ready`.
- mem_en, mem_we  out  1  RAM access strobes.
- mem_addr  out  $clog2(MEM_WORDS)  word index.
- mem_wdata  out  32 / mem_wmask  out  4  RAM write data and byte enables.
- mem_rdata  in  32  RAM read data, synchronous, valid one cycle after mem_en.
- stall_cnt  out  CNT_W  saturating count of cycles with cpu_stall=1.

## Operation
- FSM states: IDLE, RESP_CPU, RESP_DBG.
- **IDLE, no request:** stay in IDLE.
- **IDLE, one or both requests:** pick a winner.
  - Drive the mem_* signals combinationally from the winner's fields in the same cycle.
  - Next state is the RESP state of the winner.
  - Record the winner in `last_grant`.
- **Error check:** an access is an error if `addr[1:0] != 0` or `addr[ADDR_W-1:2] >= MEM_WORDS`.
  - An errored access drives mem_en=0.
  - It still proceeds to its RESP state.
  - Its RESP cycle returns err=1 and rdata=0.
- **RESP_x:** assert x_ready for exactly one cycle.
  - For a good load, `x_rdata = mem_rdata`.
  - For a store, `x_rdata = 0`.
  - Next state is always IDLE.
- A request still high in the cycle after its ready is a new request, e.g. back-to-back CPU loads.
- **Arbitration:** fixed or round-robin, selected by macro (see Configuration).
- **stall_cnt:** +1 every cycle cpu_stall=1; saturates at all-ones and does not wrap.
- **Reset (any state, including mid-access):** next state IDLE, last_grant=DBG, stall_cnt=0.
  - A pending access is dropped without a ready.
  - The requester re-issues it after reset.

## Timing
- Reset values: all ready, err, mem_en, mem_we are 0; rdata, mem_addr, mem_wdata, mem_wmask are 0; stall_cnt=0; cpu_stall follows cpu_req.
- Latency: request seen in IDLE at cycle N, RAM edge at end of N, ready in N+1.
- Throughput: one access per 2 cycles.
- A losing requester waits at least 2 extra cycles per access granted ahead of it.
- mem_* is active only in IDLE-grant cycles; it is 0 in RESP states.
- A store's RAM write occurs at the end of cycle N; ready in N+1 confirms it.
- Simultaneous requests in IDLE: exactly one grant per cycle, never both.
- Requester fields are sampled only in the grant cycle.
- Fields that change while req is high are a protocol violation and are unchecked.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin.
  - On a tie, grant the port opposite `last_grant`.
  - Because reset sets last_grant=DBG, the first tie goes to the CPU.
- `DMEM_ARB_RR_EN` undefined: fixed priority, debug over CPU.
  - last_grant is still tracked but ignored.
  - A continuously requesting debug port starves the CPU; this is the intended loader behaviour.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (IDLE, RESP_CPU, RESP_DBG);
  - the grant enum (GNT_CPU, GNT_DBG);
  - the default debug write mask 4'hF.
- Sub-module `dmem_arb_pick`: combinational winner selection from cpu_req, dbg_req, last_grant and the RR macro. It holds no state.

## Test plan
- Reset, then CPU-only store 0xFFFF_FFFC to 0x200 (mask F): mem_en/we=1, mem_addr=128 in cycle N; cpu_ready=1 at N+1; cpu_stall=1 for 1 cycle; stall_cnt=1.
- Debug writes 0x0012_3456 to word 151, then CPU loads 0x25C: cpu_rdata=0x0012_3456 with cpu_ready.
- Both requesting every cycle for 8 cycles:
  - RR build: grants CPU, DBG, CPU, DBG, with readies at cycles 1, 3, 5, 7.
  - Fixed build: only dbg_ready pulses, and stall_cnt=8.
- CPU load at 0x202 and at 0x400 (word 256, MEM_WORDS=256): mem_en=0; cpu_err=1, cpu_rdata=0 with ready.
- Reset low during RESP_CPU: no cpu_ready that cycle; after release the state is IDLE and stall_cnt=0. The re-asserted request completes with 1-cycle latency.
- CNT_W=4, CPU starved for 20 cycles in the fixed build: stall_cnt holds at 15.
